// File: rtl/fetch_pkg.sv
// Shared constants and predecode helpers for the buffered fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_FBRANCH = 7'b1100001;

    // J-type immediate from instr[31:12], sign-extended with a zero LSB.
    function automatic logic [XLEN-1:0] imm_j(input logic [31:12] hi);
        return {{12{hi[31]}}, hi[19:12], hi[20], hi[30:21], 1'b0};
    endfunction

    // B-type immediate from instr[31:25] and instr[11:7].
    function automatic logic [XLEN-1:0] imm_b(input logic [31:25] f7, input logic [11:7] f5);
        return {{20{f7[31]}}, f5[7], f7[30:25], f5[11:8], 1'b0};
    endfunction

    // A clear LSB marks a 64-bit instruction.
    function automatic logic is_64(input logic lsb);
        return ~lsb;
    endfunction

    function automatic logic is_jal(input logic [6:0] op);
        return op == OP_JAL;
    endfunction

    function automatic logic is_branch(input logic [6:0] op);
        return (op == OP_BRANCH) || (op == OP_FBRANCH);
    endfunction

endpackage

// File: rtl/fetch_buffered_queue.sv
// Circular instruction FIFO with a synchronous flush that wins over push/pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [W-1:0]           wdata_i,
    input  logic                   pop_i,
    output logic [W-1:0]           head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_buffered.sv
// Fetch stage: one imem request in flight, predecode-driven next PC, and a
// DEPTH-entry queue toward decode; a backend redirect flushes and restarts fetch.
module fetch_buffered
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned GHR_W    = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             imem_en,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic [31:0]      imem_rdata1,
    input  logic             bp_taken,
    input  logic [GHR_W-1:0] bp_index,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_instr1,
    output logic             out_pred_taken,
    output logic [GHR_W-1:0] out_bp_index
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      instr;
        logic [31:0]      instr1;
        logic             pred_taken;
        logic [GHR_W-1:0] bp_index;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] resp_pc_q, resp_pc_d;
    logic        inflight_q, inflight_d;

    logic             is_jal_c, is_branch_c, pred_taken_c;
    logic [31:0]      pred_next_c, cand_c;
    logic             push_c, pop_c, issue_c;
    logic [OCC_W-1:0] occ_c;

    fetch_entry_t     wr_entry, head_entry;
    logic [CNT_W-1:0] q_count;
    logic             q_empty, q_full;

    // Predecode of the returning word selects the sequential or predicted target.
    always_comb begin
        is_jal_c     = is_jal(imem_rdata[6:0]);
        is_branch_c  = is_branch(imem_rdata[6:0]);
        pred_taken_c = is_jal_c | (is_branch_c & bp_taken);
        if (is_jal_c) begin
            pred_next_c = resp_pc_q + imm_j(imem_rdata[31:12]);
        end else if (is_branch_c && bp_taken) begin
            pred_next_c = resp_pc_q + imm_b(imem_rdata[31:25], imem_rdata[11:7]);
        end else if (is_64(imem_rdata[0])) begin
            pred_next_c = resp_pc_q + 32'd8;
        end else begin
            pred_next_c = resp_pc_q + 32'd4;
        end
    end

    // A fetch may issue only if its response is guaranteed a queue slot.
    always_comb begin
        push_c    = inflight_q & ~redirect_valid;
        out_valid = ~q_empty & ~redirect_valid;
        pop_c     = out_valid & out_ready;
        occ_c     = OCC_W'(q_count) + OCC_W'(push_c) - OCC_W'(pop_c);
        issue_c   = redirect_valid | (occ_c < OCC_W'(DEPTH));
        if (redirect_valid) begin
            cand_c = redirect_pc;
        end else if (inflight_q) begin
            cand_c = pred_next_c;
        end else begin
            cand_c = fetch_pc_q;
        end
    end

    assign imem_en   = rstn & issue_c;
    assign imem_addr = cand_c;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q;
        if (issue_c) begin
            resp_pc_d  = cand_c;
            inflight_d = 1'b1;
        end else begin
            fetch_pc_d = cand_c;
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
        end
    end

    always_comb begin
        wr_entry            = '0;
        wr_entry.pc         = resp_pc_q;
        wr_entry.instr      = imem_rdata;
        wr_entry.instr1     = imem_rdata1;
        wr_entry.pred_taken = pred_taken_c;
        wr_entry.bp_index   = bp_index;
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_queue (
        .clk     (clk),
        .rstn    (rstn),
        .flush_i (redirect_valid),
        .push_i  (push_c),
        .wdata_i (wr_entry),
        .pop_i   (pop_c),
        .head_o  (head_entry),
        .count_o (q_count),
        .empty_o (q_empty),
        .full_o  (q_full)
    );

    assign out_pc         = head_entry.pc;
    assign out_instr      = head_entry.instr;
    assign out_instr1     = head_entry.instr1;
    assign out_pred_taken = head_entry.pred_taken;
    assign out_bp_index   = head_entry.bp_index;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(q_full && push_c && !pop_c));

endmodule

// File: tb/tb_fetch_buffered.sv
// Randomized bench for fetch_buffered against a queue-based reference model.
module tb_fetch_buffered;

    localparam int DEPTH = 4;
    localparam int GHR_W = 8;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             redirect_valid = 1'b0;
    logic [31:0]      redirect_pc = '0;
    logic             imem_en;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_rdata = '0;
    logic [31:0]      imem_rdata1 = '0;
    logic             bp_taken = 1'b0;
    logic [GHR_W-1:0] bp_index = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [31:0]      out_pc, out_instr, out_instr1;
    logic             out_pred_taken;
    logic [GHR_W-1:0] out_bp_index;

    fetch_buffered #(.DEPTH(DEPTH), .GHR_W(GHR_W), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_rdata1    (imem_rdata1),
        .bp_taken       (bp_taken),
        .bp_index       (bp_index),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_instr1     (out_instr1),
        .out_pred_taken (out_pred_taken),
        .out_bp_index   (out_bp_index)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      instr;
        logic [31:0]      instr1;
        logic             pred;
        logic [GHR_W-1:0] idx;
    } exp_t;

    int checks = 0;
    int errors = 0;

    logic [31:0] prog [logic [31:0]];
    exp_t        sb [$];
    bit          last_iss;
    logic [31:0] last_pc, held_pc;
    int          bp_mode = 0;

    bit               obs_en, obs_valid, obs_pop, obs_pred;
    logic [31:0]      obs_addr, obs_pc, obs_instr1;
    logic [GHR_W-1:0] obs_idx, drv_idx;

    function automatic logic [31:0] word(input logic [31:0] a);
        return prog.exists(a) ? prog[a] : 32'h0000_0013;
    endfunction

    function automatic logic [31:0] enc_jal(input logic [31:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_br(input logic [31:0] imm, input bit fb);
        return {imm[12], imm[10:5], 5'd2, 5'd1, 3'd0, imm[4:1], imm[11],
                fb ? 7'b1100001 : 7'b1100011};
    endfunction

    function automatic bit m_jal(input logic [31:0] w);
        return w[6:0] == 7'b1101111;
    endfunction

    function automatic bit m_br(input logic [31:0] w);
        return (w[6:0] == 7'b1100011) || (w[6:0] == 7'b1100001);
    endfunction

    // Next fetch address from the instruction set rules, using integer arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic bp);
        logic [31:0] w;
        int imm;
        w = word(pc);
        if (m_jal(w)) begin
            imm = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096
                  - (w[31] ? 1048576 : 0);
            return pc + 32'(imm);
        end
        if (m_br(w) && bp) begin
            imm = int'(w[11:8]) * 2 + int'(w[30:25]) * 32 + int'(w[7]) * 2048
                  - (w[31] ? 4096 : 0);
            return pc + 32'(imm);
        end
        return w[0] ? pc + 32'd4 : pc + 32'd8;
    endfunction

    task automatic model_reset();
        sb.delete();
        last_iss = 1'b0;
        held_pc  = 32'h0;
        last_pc  = 32'h0;
    endtask

    task automatic reset_dut();
        rstn = 1'b0;
        redirect_valid = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
    endtask

    // One clock of the reference model: supply the imem response, compare, advance.
    task automatic model_cycle();
        int   n;
        bit   push, pop_e, vld_e, en_e;
        logic [31:0] cand_e, w;
        exp_t e;
        @(negedge clk);
        if (last_iss) begin
            imem_rdata  = word(last_pc);
            imem_rdata1 = word(last_pc + 32'd4);
            bp_taken    = (bp_mode == 1) ? 1'b1 : (bp_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            bp_index    = GHR_W'($urandom);
        end else begin
            imem_rdata  = $urandom;
            imem_rdata1 = $urandom;
            bp_taken    = 1'($urandom_range(0, 1));
            bp_index    = GHR_W'($urandom);
        end
        drv_idx = bp_index;
        #1;
        n      = sb.size();
        push   = last_iss && !redirect_valid;
        vld_e  = (n != 0) && !redirect_valid;
        pop_e  = vld_e && out_ready;
        en_e   = redirect_valid || ((n + int'(push) - int'(pop_e)) < DEPTH);
        cand_e = redirect_valid ? redirect_pc : last_iss ? model_next(last_pc, bp_taken) : held_pc;

        obs_en = imem_en; obs_addr = imem_addr; obs_valid = out_valid;
        obs_pop = out_valid && out_ready; obs_pc = out_pc; obs_instr1 = out_instr1;
        obs_pred = out_pred_taken; obs_idx = out_bp_index;

        checks++;
        if (out_valid !== vld_e) begin
            errors++; $display("FAIL out_valid act=%b exp=%b t=%0t", out_valid, vld_e, $time);
        end
        checks++;
        if (imem_en !== en_e) begin
            errors++; $display("FAIL imem_en act=%b exp=%b t=%0t", imem_en, en_e, $time);
        end
        checks++;
        if (imem_addr !== cand_e) begin
            errors++; $display("FAIL imem_addr act=%h exp=%h t=%0t", imem_addr, cand_e, $time);
        end
        if (pop_e) begin
            e = sb[0];
            checks++;
            if ({out_pc, out_instr, out_instr1, out_pred_taken, out_bp_index} !== e) begin
                errors++;
                $display("FAIL head act=%h/%h/%h/%b/%h exp=%h/%h/%h/%b/%h t=%0t",
                         out_pc, out_instr, out_instr1, out_pred_taken, out_bp_index,
                         e.pc, e.instr, e.instr1, e.pred, e.idx, $time);
            end
        end

        if (redirect_valid) begin
            sb.delete();
        end else begin
            if (pop_e) void'(sb.pop_front());
            if (push) begin
                w = word(last_pc);
                e = '{pc: last_pc, instr: w, instr1: word(last_pc + 32'd4),
                      pred: m_jal(w) || (m_br(w) && bp_taken), idx: bp_index};
                sb.push_back(e);
            end
        end
        last_iss = en_e;
        if (en_e) last_pc = cand_e;
        else      held_pc = cand_e;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        prog.delete();
        out_ready = 1'b1;
        imem_rdata = $urandom;
        @(posedge clk);
        #1;
        checks++;
        if (imem_en !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_handshake act=%b/%b exp=0/0", imem_en, out_valid);
        end
        checks++;
        if (imem_addr !== 32'h0) begin
            errors++; $display("FAIL reset_addr act=%h exp=00000000", imem_addr);
        end
        checks++;
        if ({out_pc, out_instr, out_instr1, out_pred_taken, out_bp_index} !== '0) begin
            errors++; $display("FAIL reset_head act=%h/%h/%h/%b/%h exp=0", out_pc, out_instr,
                               out_instr1, out_pred_taken, out_bp_index);
        end
        rstn = 1'b1;
        model_reset();
        for (int k = 0; k < 5; k++) begin
            model_cycle();
            checks++;
            if (obs_en !== 1'b1 || obs_addr !== 32'(4 * k)) begin
                errors++; $display("FAIL seq_addr k=%0d act=%b/%h exp=1/%h", k, obs_en, obs_addr, 4 * k);
            end
            checks++;
            if (obs_valid !== (k >= 2)) begin
                errors++; $display("FAIL seq_valid k=%0d act=%b exp=%b", k, obs_valid, k >= 2);
            end
            if (k >= 2) begin
                checks++;
                if (obs_pc !== 32'(4 * (k - 2))) begin
                    errors++; $display("FAIL seq_pc k=%0d act=%h exp=%h", k, obs_pc, 4 * (k - 2));
                end
            end
        end
    endtask

    task automatic test_jal();
        prog.delete();
        prog[32'h10] = enc_jal(32'h20);
        reset_dut();
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            model_cycle();
            if (k == 5) begin
                checks++;
                if (obs_addr !== 32'h30) begin
                    errors++; $display("FAIL jal_target act=%h exp=00000030", obs_addr);
                end
            end
            if (k == 6) begin
                checks++;
                if (obs_pc !== 32'h10 || obs_pred !== 1'b1) begin
                    errors++; $display("FAIL jal_pred act=%h/%b exp=00000010/1", obs_pc, obs_pred);
                end
            end
        end
    endtask

    task automatic test_branch();
        logic [GHR_W-1:0] idx1;
        bit found = 0;
        prog.delete();
        prog[32'h40] = enc_br(32'hFFFF_FFF8, 1'b0);
        reset_dut();
        out_ready = 1'b1;
        bp_mode = 1;
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        model_cycle();
        redirect_valid = 1'b0;
        model_cycle();
        checks++;
        if (obs_addr !== 32'h38) begin
            errors++; $display("FAIL br_taken act=%h exp=00000038", obs_addr);
        end
        bp_mode = 2;
        redirect_valid = 1'b1;
        model_cycle();
        redirect_valid = 1'b0;
        model_cycle();
        idx1 = drv_idx;
        checks++;
        if (obs_addr !== 32'h44) begin
            errors++; $display("FAIL br_not_taken act=%h exp=00000044", obs_addr);
        end
        for (int k = 0; k < 10 && !found; k++) begin
            model_cycle();
            if (obs_pop && obs_pc == 32'h40) begin
                found = 1;
                checks++;
                if (obs_idx !== idx1 || obs_pred !== 1'b0) begin
                    errors++; $display("FAIL br_index act=%h/%b exp=%h/0", obs_idx, obs_pred, idx1);
                end
            end
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL br_drain act=absent exp=pc 00000040");
        end
        bp_mode = 0;
    endtask

    task automatic test_wide();
        bit found = 0;
        prog.delete();
        prog[32'h80] = 32'h0000_0012;
        prog[32'h84] = 32'hDEAD_BEEF;
        reset_dut();
        out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        model_cycle();
        redirect_valid = 1'b0;
        model_cycle();
        checks++;
        if (obs_addr !== 32'h88) begin
            errors++; $display("FAIL wide_next act=%h exp=00000088", obs_addr);
        end
        for (int k = 0; k < 10 && !found; k++) begin
            model_cycle();
            if (obs_pop && obs_pc == 32'h80) begin
                found = 1;
                checks++;
                if (obs_instr1 !== 32'hDEAD_BEEF) begin
                    errors++; $display("FAIL wide_instr1 act=%h exp=deadbeef", obs_instr1);
                end
            end
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL wide_drain act=absent exp=pc 00000080");
        end
    endtask

    task automatic test_full_redirect();
        int issues = 0;
        prog.delete();
        reset_dut();
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            model_cycle();
            if (obs_en) issues++;
        end
        checks++;
        if (issues != DEPTH || obs_en !== 1'b0 || obs_valid !== 1'b1) begin
            errors++; $display("FAIL full_stall act=%0d/%b/%b exp=%0d/0/1", issues, obs_en, obs_valid, DEPTH);
        end
        out_ready = 1'b1;
        model_cycle();
        checks++;
        if (obs_en !== 1'b1 || obs_pop !== 1'b1) begin
            errors++; $display("FAIL full_resume act=%b/%b exp=1/1", obs_en, obs_pop);
        end
        out_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        model_cycle();
        checks++;
        if (obs_en !== 1'b1 || obs_addr !== 32'h200 || obs_valid !== 1'b0) begin
            errors++; $display("FAIL redir_issue act=%b/%h/%b exp=1/00000200/0", obs_en, obs_addr, obs_valid);
        end
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        model_cycle();
        checks++;
        if (obs_valid !== 1'b0) begin
            errors++; $display("FAIL redir_gap act=%b exp=0", obs_valid);
        end
        model_cycle();
        checks++;
        if (obs_valid !== 1'b1 || obs_pc !== 32'h200) begin
            errors++; $display("FAIL redir_head act=%b/%h exp=1/00000200", obs_valid, obs_pc);
        end
    endtask

    task automatic test_random();
        int imm;
        int r;
        prog.delete();
        for (int a = 0; a < 128; a++) begin
            r   = int'($urandom_range(0, 9));
            imm = (int'($urandom_range(0, 63)) - 32) * 4;
            if (r < 2)       prog[32'(a * 4)] = enc_jal(32'(imm));
            else if (r < 4)  prog[32'(a * 4)] = enc_br(32'(imm), r == 3);
            else if (r == 4) prog[32'(a * 4)] = $urandom & 32'hFFFF_FFFE;
            else             prog[32'(a * 4)] = $urandom;
        end
        reset_dut();
        for (int i = 0; i < 1500; i++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 40) == 0);
            redirect_pc    = 32'($urandom_range(0, 127)) * 32'd4;
            model_cycle();
            if (i == 700) begin
                rstn = 1'b0;
                #1;
                checks++;
                if (imem_en !== 1'b0 || out_valid !== 1'b0 || out_pc !== 32'h0) begin
                    errors++; $display("FAIL async_reset act=%b/%b/%h exp=0/0/0", imem_en, out_valid, out_pc);
                end
                @(posedge clk);
                #1;
                rstn = 1'b1;
                model_reset();
            end
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_jal();
        test_branch();
        test_wide();
        test_full_redirect();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_buffered.md
Name: fetch_buffered

Overview:
Parametrised fetch stage that decouples instruction memory from decode through a DEPTH-entry instruction queue with a valid/ready output.
Keeps one fetch in flight to a 1-cycle synchronous imem. Predecodes each returned word (JAL, branch/fbranch, 64-bit length) to pick the next fetch address, using the predictor's taken bit.
Sits between imem/branch predictor and decode. Backend mispredict/jump misses arrive as a redirect that flushes the queue.

Parameters:
DEPTH, 4, queue entries; power of two, at least 2
GHR_W, 8, width of the predictor index carried with each instruction
RESET_PC, 32'h0, first fetch address after reset

Ports:
clk  in  1  clock
rstn  in  1  reset; asynchronous, active-low
redirect_valid  in  1  backend miss; restart fetch at redirect_pc
redirect_pc  in  32  corrected PC
imem_en  out  1  fetch issued this cycle
imem_addr  out  32  byte fetch address (valid when imem_en)
imem_rdata  in  32  word at the previous cycle's imem_addr
imem_rdata1  in  32  word at the previous cycle's imem_addr+4
bp_taken  in  1  prediction for the previous cycle's imem_addr; aligned with imem_rdata
bp_index  in  GHR_W  pc xor global history for that fetch; aligned with imem_rdata
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head
out_pc  out  32  head PC
out_instr  out  32  head word
out_instr1  out  32  head second word (64-bit instructions)
out_pred_taken  out  1  head branch was predicted taken (JAL reports 1)
out_bp_index  out  GHR_W  head predictor index

Behaviour:
- State:
  - fetch_pc: next address to issue.
  - inflight: 1 bit.
  - resp_pc: address of the fetch in flight.
  - Queue storage with rd_ptr, wr_ptr and count.
- Reset (async assert, sync release):
  - fetch_pc=RESET_PC, inflight=0, count=0, pointers=0.
  - out_valid=0 and imem_en=0; all other outputs 0.
  - imem_addr=RESET_PC.
- Response: when inflight=1, imem_rdata, imem_rdata1, bp_taken and bp_index belong to resp_pc.
- Predecode of the response:
  - opcode 1101111 (JAL): next = resp_pc + imm_j.
  - opcode 1100011 or 1100001 (branch/fbranch) with bp_taken: next = resp_pc + imm_b.
  - otherwise, bit0==0 (64-bit instruction): next = resp_pc + 8.
  - otherwise: next = resp_pc + 4.
  - All sums are mod 2^32. Immediates use the RV32 J/B encodings, sign-extended, with a zero LSB.
- push = inflight & ~redirect_valid. The entry stores {resp_pc, rdata, rdata1, pred_taken, bp_index}. pred_taken = is_jal | (is_branch & bp_taken).
- pop = out_valid & out_ready.
- out_valid = (count != 0) & ~redirect_valid. Head fields come combinationally from the rd_ptr entry.
- Candidate address: redirect_pc if redirect_valid; else the predecoded next if inflight; else fetch_pc.
- Issue rule:
  - imem_en=1 when redirect_valid, or when (count + push - pop) < DEPTH.
  - imem_addr = candidate, driven combinationally in the same cycle.
  - On issue: resp_pc <= candidate, inflight <= 1.
  - Without issue: fetch_pc <= candidate, inflight <= 0.
- Throughput is one instruction per cycle while the queue drains. The queue never overflows, because each issue reserves a slot.
- Redirect has priority over everything in the same cycle:
  - count=0, pointers reset.
  - The current response is dropped; no pop.
  - redirect_pc is issued that cycle.
  - Its data is pushed one cycle later.
- Full queue with out_ready=0: imem_en=0, the address is held in fetch_pc, no push. Issue resumes the cycle a pop makes room.
- Empty queue: out_valid=0; out_ready is ignored.
- Simultaneous push and pop at count==DEPTH cannot occur. Push at count==DEPTH-1 with pop keeps count unchanged.
- Pointers wrap modulo DEPTH.
- rstn asserted mid-operation clears everything immediately. Responses arriving after reset are ignored because inflight=0.

Decomposition:
- Package fetch_pkg:
  - opcode constants OP_JAL, OP_BRANCH, OP_FBRANCH.
  - functions imm_j(), imm_b() and is_64().
  - typedef fetch_entry_t, parametrised on GHR_W via the module.
- Sub-module fetch_queue: circular FIFO with synchronous flush.
  - Ports: push, entry in, pop, head out, count, empty/full.

Test Plan:
- Reset release, all words 32'h00000013, out_ready=1 -> imem_addr 0,4,8,0xC on consecutive cycles. out_pc sequence 0,4,8 with out_valid first high 2 cycles after reset release.
- Word at 0x10 = JAL imm +0x20 -> the next imem_addr after the 0x10 response is 0x30, and out_pred_taken=1 for pc 0x10.
- Branch at 0x40 with imm_b=-8: bp_taken=1 -> next addr 0x38; bp_taken=0 -> next addr 0x44. out_bp_index equals the bp_index driven with that response.
- 64-bit word (bit0=0) at 0x80, rdata1=0xDEADBEEF -> next addr 0x88, out_instr1=0xDEADBEEF.
- DEPTH=4, out_ready=0 -> exactly 4 entries queued, imem_en low thereafter. One pop -> imem_en high the same cycle, and no entry is lost or duplicated.
- Full queue plus inflight fetch, redirect_valid=1 with pc 0x200 -> imem_addr=0x200 that cycle, out_valid=0 that cycle and the next. The stale response is not enqueued; the next out_pc is 0x200.
